agc_gain_ctrl: RTL and testbench



---
 rtl/agc_gain_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_agc_gain_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/agc_gain_ctrl.sv
// rtl/agc_gain_ctrl.sv - AGC loop filter: dead-band compare, clamped gain step, settle blanking, lock detect
// Optional fast acquisition enabled by defining AGC_FAST_ACQ_EN.
module agc_gain_ctrl #(
   parameter int                GAIN_W     = 8,
   parameter logic [GAIN_W-1:0] GAIN_MAX   = 8'hFF,
   parameter logic [GAIN_W-1:0] GAIN_MIN   = 8'h00,
   parameter int                STEP_SHIFT = 2,
   parameter int                LOCK_CNT   = 4,
   parameter int                SETTLE_CYC = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              agc_en,
   input  logic [8:0]        pwr_est_dB,
   input  logic              pwr_est_end,
   input  logic [8:0]        pwr_req_val,
   input  logic [3:0]        hyst_dB,
   input  logic [GAIN_W-1:0] gain_init,
   output logic [GAIN_W-1:0] gain_code,
   output logic              gain_upd,
   output logic              agc_lock,
   output logic              gain_at_max,
   output logic              gain_at_min
);

   localparam int         SW        = GAIN_W + 2;
   localparam logic [3:0] LOCK_MAX  = 4'(LOCK_CNT);
   localparam logic [9:0] SETTLE_LD = 10'(SETTLE_CYC - 1);

   typedef enum logic [1:0] {IDLE, WAIT_EST, CALC, SETTLE} state_t;

   state_t            state_q, state_nxt;
   logic [9:0]        err_q, err_nxt, err_calc;
   logic [GAIN_W-1:0] gain_q, gain_nxt;
   logic              upd_q, upd_nxt;
   logic              lock_q, lock_nxt;
   logic [3:0]        lock_cnt_q, lock_cnt_nxt, lock_cnt_inc;
   logic [9:0]        settle_q, settle_nxt, settle_ld;
   logic [4:0]        shift_amt;
   logic              hold;

   logic [9:0]        abs_err, mag_raw, mag;
   logic              in_window;
   logic [SW-1:0]     step, sum;
   logic [GAIN_W-1:0] gain_new;

   assign hold     = !agc_en || (state_q == IDLE);
   assign err_calc = {1'b0, pwr_req_val} - {1'b0, pwr_est_dB};

`ifdef AGC_FAST_ACQ_EN
   localparam int         SHIFT_FAST     = (STEP_SHIFT > 0) ? STEP_SHIFT - 1 : 0;
   localparam int         SETTLE_HALF    = (SETTLE_CYC / 2 > 0) ? SETTLE_CYC / 2 : 1;
   localparam logic [9:0] SETTLE_FAST_LD = 10'(SETTLE_HALF - 1);

   logic fast_q, fast_nxt;

   // Acquisition mode lasts from each exit of IDLE until the first lock.
   always_comb begin
      fast_nxt = fast_q;
      if (hold)
         fast_nxt = 1'b1;
      else if (lock_nxt)
         fast_nxt = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset)
         fast_q <= 1'b1;
      else
         fast_q <= fast_nxt;
   end

   assign shift_amt = fast_q ? 5'(SHIFT_FAST) : 5'(STEP_SHIFT);
   assign settle_ld = fast_q ? SETTLE_FAST_LD : SETTLE_LD;
`else
   assign shift_amt = 5'(STEP_SHIFT);
   assign settle_ld = SETTLE_LD;
`endif

   // Step arithmetic is two's complement at SW bits; a set sign bit means below zero.
   always_comb begin
      abs_err   = err_q[9] ? (~err_q + 10'd1) : err_q;
      in_window = (abs_err <= {6'd0, hyst_dB});
      mag_raw   = abs_err >> shift_amt;
      mag       = (mag_raw == 10'd0) ? 10'd1 : mag_raw;
      step      = err_q[9] ? (~SW'(mag) + SW'(1)) : SW'(mag);
      sum       = {2'b00, gain_q} + step;
      if (sum[SW-1] || (sum < {2'b00, GAIN_MIN}))
         gain_new = GAIN_MIN;
      else if (sum > {2'b00, GAIN_MAX})
         gain_new = GAIN_MAX;
      else
         gain_new = sum[GAIN_W-1:0];
      lock_cnt_inc = (lock_cnt_q >= LOCK_MAX) ? LOCK_MAX : lock_cnt_q + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      if (!agc_en) begin
         state_nxt = IDLE;
      end else begin
         case (state_q)
            IDLE:     state_nxt = WAIT_EST;
            WAIT_EST: if (pwr_est_end) state_nxt = CALC;
            CALC:     state_nxt = (!in_window && (gain_new != gain_q)) ? SETTLE : WAIT_EST;
            SETTLE:   if (settle_q == 10'd0) state_nxt = WAIT_EST;
            default:  state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      err_nxt      = err_q;
      gain_nxt     = gain_q;
      upd_nxt      = 1'b0;
      lock_nxt     = lock_q;
      lock_cnt_nxt = lock_cnt_q;
      settle_nxt   = settle_q;
      if (hold) begin
         gain_nxt     = gain_init;
         lock_nxt     = 1'b0;
         lock_cnt_nxt = 4'd0;
      end else begin
         case (state_q)
            WAIT_EST: begin
               if (pwr_est_end)
                  err_nxt = err_calc;
            end
            CALC: begin
               if (in_window) begin
                  lock_cnt_nxt = lock_cnt_inc;
                  lock_nxt     = (lock_cnt_inc == LOCK_MAX);
               end else begin
                  lock_cnt_nxt = 4'd0;
                  lock_nxt     = 1'b0;
                  if (gain_new != gain_q) begin
                     gain_nxt   = gain_new;
                     upd_nxt    = 1'b1;
                     settle_nxt = settle_ld;
                  end
               end
            end
            SETTLE: begin
               if (settle_q != 10'd0)
                  settle_nxt = settle_q - 10'd1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_q      <= '0;
         gain_q     <= GAIN_MIN;
         upd_q      <= 1'b0;
         lock_q     <= 1'b0;
         lock_cnt_q <= '0;
         settle_q   <= '0;
      end else begin
         err_q      <= err_nxt;
         gain_q     <= gain_nxt;
         upd_q      <= upd_nxt;
         lock_q     <= lock_nxt;
         lock_cnt_q <= lock_cnt_nxt;
         settle_q   <= settle_nxt;
      end
   end

   assign gain_code   = gain_q;
   assign gain_upd    = upd_q;
   assign agc_lock    = lock_q;
   assign gain_at_max = (gain_q == GAIN_MAX);
   assign gain_at_min = (gain_q == GAIN_MIN);

endmodule

// File: tb/tb_agc_gain_ctrl.sv
// tb/tb_agc_gain_ctrl.sv - bench for agc_gain_ctrl against an arithmetic loop model
module tb_agc_gain_ctrl;
   localparam int LOCK_CNT   = 4;
   localparam int STEP_SHIFT = 2;
   localparam int SETTLE_CYC = 64;
`ifdef AGC_FAST_ACQ_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset, agc_en, pwr_est_end;
   logic [8:0] pwr_est_dB, pwr_req_val;
   logic [3:0] hyst_dB;
   logic [7:0] gain_init, gain_code;
   logic       gain_upd, agc_lock, gain_at_max, gain_at_min;

   int n_pass = 0;
   int n_total = 0;
   int m_gain, m_lock_cnt;
   bit m_lock, m_fast;

   agc_gain_ctrl dut (
      .clk(clk), .reset(reset), .agc_en(agc_en),
      .pwr_est_dB(pwr_est_dB), .pwr_est_end(pwr_est_end),
      .pwr_req_val(pwr_req_val), .hyst_dB(hyst_dB), .gain_init(gain_init),
      .gain_code(gain_code), .gain_upd(gain_upd), .agc_lock(agc_lock),
      .gain_at_max(gain_at_max), .gain_at_min(gain_at_min)
   );

   always #16 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic chk_outputs(input string tag);
      chk({tag, "_gain"}, 32'(gain_code), m_gain);
      chk({tag, "_lock"}, 32'(agc_lock), 32'(m_lock));
      chk({tag, "_max"}, 32'(gain_at_max), 32'(m_gain == 255));
      chk({tag, "_min"}, 32'(gain_at_min), 32'(m_gain == 0));
   endtask

   task automatic model_hold(input int g);
      m_gain = g;
      m_lock_cnt = 0;
      m_lock = 1'b0;
      m_fast = FAST;
   endtask

   task automatic enable(input int gi);
      agc_en = 1'b0;
      gain_init = 8'(gi);
      tick();
      tick();
      model_hold(gi);
      chk_outputs("idle");
      chk("idle_upd", 32'(gain_upd), 0);
      agc_en = 1'b1;
      tick();
   endtask

   // drop_c: cycle after the strobe at which agc_en drops (or reset rises when use_rst)
   task automatic send_est(input int req, input int est, input int hyst,
                           input int drop_c = 0, input bit use_rst = 1'b0);
      int err, aerr, mag, newg, sh, s_len;
      bit upd_e;
      pwr_req_val = 9'(req);
      pwr_est_dB  = 9'(est);
      hyst_dB     = 4'(hyst);
      pwr_est_end = 1'b1;
      tick();
      pwr_est_end = 1'b0;
      chk("n1_gain", 32'(gain_code), m_gain);
      chk("n1_upd", 32'(gain_upd), 0);
      if (drop_c == 1) begin
         if (use_rst) reset = 1'b1; else agc_en = 1'b0;
         tick();
         reset = 1'b0;
         model_hold(use_rst ? 0 : int'(gain_init));
         chk_outputs("drop_calc");
         chk("drop_calc_upd", 32'(gain_upd), 0);
         return;
      end
      err  = req - est;
      aerr = (err < 0) ? -err : err;
      upd_e = 1'b0;
      s_len = (FAST && m_fast) ? SETTLE_CYC / 2 : SETTLE_CYC;
      if (aerr <= hyst) begin
         m_lock_cnt = (m_lock_cnt + 1 > LOCK_CNT) ? LOCK_CNT : m_lock_cnt + 1;
         m_lock = (m_lock_cnt == LOCK_CNT);
         if (m_lock) m_fast = 1'b0;
      end else begin
         sh  = (FAST && m_fast) ? STEP_SHIFT - 1 : STEP_SHIFT;
         mag = aerr >> sh;
         if (mag == 0) mag = 1;
         newg = m_gain + ((err < 0) ? -mag : mag);
         if (newg > 255) newg = 255;
         if (newg < 0) newg = 0;
         m_lock_cnt = 0;
         m_lock = 1'b0;
         upd_e = (newg != m_gain);
         m_gain = newg;
      end
      tick();
      chk_outputs("n2");
      chk("n2_upd", 32'(gain_upd), 32'(upd_e));
      tick();
      chk("n3_upd", 32'(gain_upd), 0);
      if (!upd_e) return;
      for (int c = 3; c <= s_len + 1; c++) begin
         if (c == drop_c) begin
            if (use_rst) reset = 1'b1; else agc_en = 1'b0;
            tick();
            reset = 1'b0;
            model_hold(use_rst ? 0 : int'(gain_init));
            chk_outputs("drop_settle");
            chk("drop_settle_upd", 32'(gain_upd), 0);
            return;
         end
         chk("settle_gain", 32'(gain_code), m_gain);
         chk("settle_upd", 32'(gain_upd), 0);
         pwr_req_val = 9'h1FF;
         pwr_est_dB  = 9'h000;
         pwr_est_end = (c == 10) || (c == s_len + 1);
         tick();
      end
      pwr_est_end = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      agc_en = 1'b0;
      pwr_est_end = 1'b0;
      pwr_est_dB = '0;
      pwr_req_val = '0;
      hyst_dB = '0;
      gain_init = 8'h80;
      tick();
      model_hold(0);
      chk_outputs("reset");
      chk("reset_upd", 32'(gain_upd), 0);
      reset = 1'b0;
      tick();
      model_hold(8'h80);
      chk_outputs("init");
      chk("init_upd", 32'(gain_upd), 0);

      enable(8'h80);
      send_est(9'h100, 9'h0C0, 4);

      enable(8'hF8);
      send_est(9'h140, 9'h100, 4);
      send_est(9'h140, 9'h100, 4);
      send_est(9'h100, 9'h140, 4);

      for (int i = 0; i < 4; i++) send_est(9'h100, 9'h102, 4);
      send_est(9'h114, 9'h100, 4);

      send_est(9'h103, 9'h100, 0);
      send_est(9'h100, 9'h103, 0);

      enable(8'h02);
      send_est(9'h100, 9'h140, 4);
      send_est(9'h100, 9'h140, 4);

      enable(8'h40);
      gain_init = 8'h33;
      send_est(9'h100, 9'h0C0, 4, 20);
      enable(8'h50);
      gain_init = 8'h21;
      send_est(9'h100, 9'h0C0, 4, 1);
      enable(8'h60);
      send_est(9'h100, 9'h0C0, 4, 15, 1'b1);
      enable(8'h70);
      send_est(9'h100, 9'h0C0, 4, 1, 1'b1);

      enable(int'($urandom_range(0, 255)));
      for (int i = 0; i < 40; i++) begin
         int req, est;
         req = int'($urandom_range(0, 511));
         if ($urandom_range(0, 1) == 0) begin
            est = req + int'($urandom_range(0, 24)) - 12;
            if (est < 0) est = 0;
            if (est > 511) est = 511;
         end else begin
            est = int'($urandom_range(0, 511));
         end
         send_est(req, est, int'($urandom_range(0, 15)));
         repeat ($urandom_range(0, 3)) tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
